// File: rtl/perceptron_sequencer_if.sv
// Bus between the perceptron sequencer, its image ROM, the weight source and the display side.
// The slave modport is the sequencer's view; the master modport is its environment's view.
interface perceptron_sequencer_if #(
   parameter int NUM_MULTS = 16,
   parameter int ACC_W     = 22
);
   logic                        start;
   logic [7:0]                  image_address;
   logic [8*NUM_MULTS-1:0]      weights_flat;
   logic [7:0]                  rom_addr;
   logic [8*NUM_MULTS-1:0]      rom_data;
   logic                        busy;
   logic                        done;
   logic signed [ACC_W-1:0]     dot_sum;
   logic                        prediction;

   modport slave (
      input  start, image_address, weights_flat, rom_data,
      output rom_addr, busy, done, dot_sum, prediction
   );

   modport master (
      output start, image_address, weights_flat, rom_data,
      input  rom_addr, busy, done, dot_sum, prediction
   );
endinterface

// File: rtl/perceptron_sequencer.sv
// Sequenced perceptron: fetches one ROM row and folds all pixel*weight products through one
// shared 8x8 multiplier, then adds the bias and thresholds the signed sum.
module perceptron_sequencer #(
   parameter int                      NUM_MULTS  = 16,
   parameter int                      ACC_W      = 22,
   parameter logic signed [ACC_W-1:0] BIAS       = 22'sd2048,
   parameter bit                      AUTO_START = 1'b0
) (
   input logic                   clk_12MHz,
   input logic                   rst_n,
   perceptron_sequencer_if.slave bus
);

   localparam int ROW_W = 8 * NUM_MULTS;
   localparam int IDX_W = $clog2(NUM_MULTS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MULTS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_LOAD,
      S_MAC,
      S_BIAS,
      S_DONE
   } state_t;

   state_t                  state_q, state_d;
   logic [7:0]              rom_addr_q, rom_addr_d;
   logic [ROW_W-1:0]        pix_q, pix_d;
   logic [ROW_W-1:0]        wgt_q, wgt_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic signed [ACC_W-1:0] dot_sum_q, dot_sum_d;
   logic                    prediction_q, prediction_d;

   logic                    start_ok;
   logic signed [16:0]      product;
   logic signed [ACC_W-1:0] biased;

   always_comb begin
      state_d      = state_q;
      rom_addr_d   = rom_addr_q;
      pix_d        = pix_q;
      wgt_d        = wgt_q;
      acc_d        = acc_q;
      idx_d        = idx_q;
      dot_sum_d    = dot_sum_q;
      prediction_d = prediction_q;

      start_ok = bus.start || (AUTO_START && (bus.image_address != rom_addr_q));
      // Pixel is unsigned, so widen with a zero before the signed multiply.
      product  = $signed({1'b0, pix_q[7:0]}) * $signed(wgt_q[7:0]);
      biased   = acc_q + BIAS;

      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (start_ok) begin
               rom_addr_d = bus.image_address;
               state_d    = S_ADDR;
            end
         end
         S_ADDR: state_d = S_LOAD;
         S_LOAD: begin
            pix_d   = bus.rom_data;
            wgt_d   = bus.weights_flat;
            acc_d   = '0;
            idx_d   = '0;
            state_d = S_MAC;
         end
         S_MAC: begin
            acc_d = acc_q + {{(ACC_W-17){product[16]}}, product};
            pix_d = pix_q >> 8;
            wgt_d = wgt_q >> 8;
            idx_d = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
               state_d = S_BIAS;
            end
         end
         S_BIAS: begin
            acc_d        = biased;
            dot_sum_d    = biased;
            prediction_d = !biased[ACC_W-1] && (biased != '0);
            state_d      = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_12MHz) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         rom_addr_q   <= '0;
         pix_q        <= '0;
         wgt_q        <= '0;
         acc_q        <= '0;
         idx_q        <= '0;
         dot_sum_q    <= '0;
         prediction_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         rom_addr_q   <= rom_addr_d;
         pix_q        <= pix_d;
         wgt_q        <= wgt_d;
         acc_q        <= acc_d;
         idx_q        <= idx_d;
         dot_sum_q    <= dot_sum_d;
         prediction_q <= prediction_d;
      end
   end

   assign bus.rom_addr   = rom_addr_q;
   assign bus.busy       = (state_q == S_ADDR) || (state_q == S_LOAD) ||
                           (state_q == S_MAC)  || (state_q == S_BIAS);
   assign bus.done       = (state_q == S_DONE);
   assign bus.dot_sum    = dot_sum_q;
   assign bus.prediction = prediction_q;

endmodule

// File: tb/tb_perceptron_sequencer.sv
// Scoreboard bench for perceptron_sequencer: directed rows with hand-computed sums,
// one instance with AUTO_START=0 and one with AUTO_START=1.
module tb_perceptron_sequencer;

   localparam int N  = 16;
   localparam int AW = 22;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   perceptron_sequencer_if #(.NUM_MULTS(N), .ACC_W(AW)) ba ();
   perceptron_sequencer_if #(.NUM_MULTS(N), .ACC_W(AW)) bb ();

   perceptron_sequencer #(
      .NUM_MULTS(N), .ACC_W(AW), .BIAS(22'sd2048), .AUTO_START(1'b0)
   ) dut_a (
      .clk_12MHz(clk), .rst_n(rst_n), .bus(ba)
   );

   perceptron_sequencer #(
      .NUM_MULTS(N), .ACC_W(AW), .BIAS(22'sd2048), .AUTO_START(1'b1)
   ) dut_b (
      .clk_12MHz(clk), .rst_n(rst_n), .bus(bb)
   );

   typedef struct packed {
      logic signed [AW-1:0] sum;
      logic                 pred;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   exp_t ea, eb;
   int   nvec = 0;
   int   nerr = 0;

   function automatic logic [8*N-1:0] rom_row(input logic [7:0] a);
      logic [8*N-1:0] r;
      case (a)
         8'h00: r = '0;
         8'h01: r = {N{8'h10}};
         8'h02: r = {N{8'hFF}};
         8'h03: for (int i = 0; i < N; i++) r[8*i +: 8] = 8'(i);
         8'h04: r = {N{8'h02}};
         8'h05: r = {N{8'h80}};
         8'h06: begin r = '0; r[7:0] = 8'hFF; end
         default: r = {N{8'h11}};
      endcase
      return r;
   endfunction

   // Registered ROM: data follows the address by one clock.
   always @(posedge clk) begin
      ba.rom_data <= rom_row(ba.rom_addr);
      bb.rom_data <= rom_row(bb.rom_addr);
   end

   task automatic chk(input string name, input longint act, input longint exp);
      nvec++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (ba.done === 1'b1) begin
         if (qa.size() == 0) begin
            nvec++; nerr++;
            $display("FAIL done_a_unexpected: got done=1 required done=0");
         end else begin
            ea = qa.pop_front();
            chk("dot_sum_a", $signed(ba.dot_sum), $signed(ea.sum));
            chk("prediction_a", ba.prediction, ea.pred);
         end
      end
      if (bb.done === 1'b1) begin
         if (qb.size() == 0) begin
            nvec++; nerr++;
            $display("FAIL done_b_unexpected: got done=1 required done=0");
         end else begin
            eb = qb.pop_front();
            chk("dot_sum_b", $signed(bb.dot_sum), $signed(eb.sum));
            chk("prediction_b", bb.prediction, eb.pred);
         end
      end
   end

   // Counts negedges from acceptance until done; optionally pokes start/inputs mid-run on A.
   task automatic wait_done(input bit sel, input bit hold, input logic [7:0] a,
                            input int poke_at, output int lat, output int bc);
      logic d;
      lat = 0;
      bc  = 0;
      do begin
         @(negedge clk);
         lat++;
         if (lat == 1 && !hold) begin
            if (sel) bb.start = 1'b0; else ba.start = 1'b0;
         end
         if (lat == 1) chk(sel ? "rom_addr_b" : "rom_addr_a", sel ? bb.rom_addr : ba.rom_addr, a);
         if (poke_at != 0 && lat == poke_at) begin
            ba.start         = 1'b1;
            ba.image_address = 8'hAA;
            ba.weights_flat  = {N{8'h80}};
         end
         if (poke_at != 0 && lat == poke_at + 1) begin
            ba.start = 1'b0;
            chk("rom_addr_hold", ba.rom_addr, a);
         end
         if (sel ? bb.busy : ba.busy) bc++;
         d = sel ? bb.done : ba.done;
      end while (!d && lat < 40);
      if (!d) begin
         nvec++; nerr++;
         $display("FAIL done_timeout: got no done in %0d cycles required done at 20", lat);
      end
   endtask

   task automatic run(input bit sel, input bit use_start, input bit hold, input logic [7:0] a,
                      input logic [8*N-1:0] w, input logic signed [AW-1:0] s,
                      input logic p, input int poke_at);
      int   lat, bc;
      exp_t e;
      e.sum  = s;
      e.pred = p;
      @(negedge clk);
      if (sel) begin
         bb.image_address = a; bb.weights_flat = w; bb.start = use_start; qb.push_back(e);
      end else begin
         ba.image_address = a; ba.weights_flat = w; ba.start = use_start; qa.push_back(e);
      end
      wait_done(sel, hold, a, poke_at, lat, bc);
      chk("latency", lat, 20);
      // busy spans ADDR, LOAD, sixteen MAC cycles and BIAS.
      chk("busy_cycles", bc, 19);
   endtask

   initial begin
      int   lat, bc, idle_busy;
      exp_t e;
      rst_n = 1'b0;
      ba.start = 1'b0; ba.image_address = '0; ba.weights_flat = '0;
      bb.start = 1'b0; bb.image_address = '0; bb.weights_flat = '0;
      repeat (3) @(negedge clk);
      chk("reset_busy", ba.busy, 0);
      chk("reset_done", ba.done, 0);
      chk("reset_dot_sum", $signed(ba.dot_sum), 0);
      chk("reset_prediction", ba.prediction, 0);
      chk("reset_rom_addr", ba.rom_addr, 0);
      rst_n = 1'b1;

      run(0, 1, 0, 8'h00, {N{8'h5A}}, 22'sd2048, 1'b1, 0);
      run(0, 1, 0, 8'h01, {N{8'hFF}}, 22'sd1792, 1'b1, 0);
      run(0, 1, 0, 8'h02, {N{8'h80}}, -22'sd520192, 1'b0, 0);
      run(0, 1, 0, 8'h03, {N{8'h01}}, 22'sd2168, 1'b1, 0);
      run(0, 1, 0, 8'h04, {N{8'h81}}, -22'sd2016, 1'b0, 0);
      run(0, 1, 0, 8'h05, {N{8'hFF}}, 22'sd0, 1'b0, 0);
      // Mid-run start pulse, address and weight change must not disturb the run.
      run(0, 1, 0, 8'h03, {N{8'h01}}, 22'sd2168, 1'b1, 5);
      repeat (25) @(negedge clk);

      // Reset during MAC (idx=7 at the tenth cycle after acceptance).
      @(negedge clk);
      ba.image_address = 8'h06; ba.weights_flat = {N{8'h01}}; ba.start = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (c == 1) ba.start = 1'b0;
      end
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_busy", ba.busy, 0);
      chk("midrst_done", ba.done, 0);
      chk("midrst_dot_sum", $signed(ba.dot_sum), 0);
      chk("midrst_prediction", ba.prediction, 0);
      chk("midrst_rom_addr", ba.rom_addr, 0);
      rst_n = 1'b1;
      repeat (25) @(negedge clk);
      chk("midrst_dot_sum_held", $signed(ba.dot_sum), 0);
      begin
         logic [8*N-1:0] w6;
         w6 = {N{8'h33}};
         w6[7:0] = 8'h02;
         w6[8*N-1 -: 8] = 8'h7F;
         run(0, 1, 0, 8'h06, w6, 22'sd2558, 1'b1, 0);
      end

      // Auto-start instance: address changes act as starts, steady address does not.
      run(1, 0, 0, 8'h03, {N{8'h01}}, 22'sd2168, 1'b1, 0);
      idle_busy = 0;
      repeat (30) begin
         @(negedge clk);
         if (bb.busy) idle_busy++;
      end
      chk("auto_idle_busy", idle_busy, 0);
      run(1, 0, 0, 8'h04, {N{8'h81}}, -22'sd2016, 1'b0, 0);
      run(1, 1, 1, 8'h04, {N{8'h81}}, -22'sd2016, 1'b0, 0);
      e.sum  = -22'sd2016;
      e.pred = 1'b0;
      qb.push_back(e);
      wait_done(1, 0, 8'h04, 0, lat, bc);
      chk("b2b_spacing", lat, 20);
      repeat (30) @(negedge clk);
      chk("queue_a_drained", qa.size(), 0);
      chk("queue_b_drained", qb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no end of test by 100000 required earlier finish");
      $fatal(1, "watchdog expired");
   end

endmodule
